// File: rtl/router_stream_sink.sv
// router_stream_sink: receives one fixed-length AXI-Stream packet per rx_start and writes it to a buffer
// Ports: clk/rst (sync, active-high); rx_start/rx_base_addr arm a packet at a base address;
// s_axis_* is the incoming stream; wr_en/wr_addr/wr_data/wr_ready is the buffer write port;
// rx_done pulses at completion, rx_err flags framing errors, pkt_cnt counts packets,
// last_lat holds the rx_start-to-rx_done cycle count of the last packet.
module router_stream_sink #(
  parameter int DATA_W    = 64,
  parameter int PKT_BEATS = 16,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_start,
  input  logic [ADDR_W-1:0] rx_base_addr,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              rx_done,
  output logic              rx_err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       last_lat
);
  localparam int IDX_W = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0] idx;
  logic [15:0] lat;
  logic acc, last_beat, end_pkt;
  assign acc       = s_axis_tvalid && s_axis_tready;
  assign last_beat = idx == IDX_W'(PKT_BEATS - 1);
  assign end_pkt   = acc && (last_beat || s_axis_tlast);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (rx_start ? RECV : IDLE) :
                state == RECV  ? (end_pkt ? DRAIN : RECV) :
                state == DRAIN ? (wr_en ? DRAIN : DONE) : IDLE;
  // A beat may enter the write register only if it is empty or being emptied this cycle.
  always_comb begin
    s_axis_tready = !rst && state == RECV && (!wr_en || wr_ready);
    rx_done       = !rst && state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      base     <= '0;
      idx      <= '0;
      lat      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rx_err   <= 1'b0;
      pkt_cnt  <= '0;
      last_lat <= '0;
    end else begin
      if (state == IDLE && rx_start) begin
        base   <= rx_base_addr;
        idx    <= '0;
        rx_err <= 1'b0;
        lat    <= '0;
      end else if (state != IDLE)
        lat <= lat + {15'd0, lat != 16'hFFFF};
      if (acc) begin
        wr_en   <= 1'b1;
        wr_addr <= base + ADDR_W'(idx);
        wr_data <= s_axis_tdata;
        idx     <= idx + 1'b1;
        // tlast must coincide exactly with the final beat: early or missing tlast is an error.
        if (s_axis_tlast != last_beat)
          rx_err <= 1'b1;
      end else if (wr_en && wr_ready)
        wr_en <= 1'b0;
      if (state == DONE) begin
        pkt_cnt  <= pkt_cnt + 16'd1;
        last_lat <= lat;
      end
    end
  end
endmodule
